// File: rtl/rng_arbiter_bank.sv
// Shared Galois LFSR serving NUM_CH requesters through a round-robin arbiter.
// Each draw is bounded to [0, limit) by masked rejection sampling with a subtract fallback.
module rng_arbiter_bank #(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       NUM_CH    = 4,
    parameter logic [WIDTH-1:0]  SEED      = 32'hACE1_2024,
    parameter logic [WIDTH-1:0]  TAPS      = 32'h8020_0003,
    parameter int unsigned       DISCARD   = 4,
    parameter int unsigned       MAX_TRIES = 8
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    seed_load,
    input  logic [WIDTH-1:0]        seed_value,
    output logic [WIDTH-1:0]        random_num_export,
    input  logic [NUM_CH-1:0]       ch_req,
    input  logic [NUM_CH*WIDTH-1:0] ch_limit,
    output logic [NUM_CH-1:0]       ch_ack,
    output logic [WIDTH-1:0]        ch_value,
    output logic                    busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (DISCARD > 1) ? $clog2(DISCARD) : 1;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TEST,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [WIDTH-1:0] value_q, value_d;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [WIDTH-1:0] lim_sel;
    logic [WIDTH-1:0] lim_m1;
    logic [WIDTH-1:0] mask_sel;
    logic [WIDTH-1:0] candidate;

    always_comb begin
        s_d = (s_q >> 1) ^ (s_q[0] ? TAPS : '0);
        if (seed_load) begin
            s_d = (seed_value == '0) ? SEED : seed_value;
        end
    end

    // Rotating priority: search starts one past the channel served last.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int off = 1; off <= int'(NUM_CH); off++) begin
            cand = int'(last_grant_q) + off;
            if (cand >= int'(NUM_CH)) begin
                cand = cand - int'(NUM_CH);
            end
            cand_idx = IDX_W'(cand);
            if (!grant_found && ch_req[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Mask is the smallest all-ones value covering lim-1, so a masked sample is < 2*lim.
    always_comb begin
        lim_sel = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (grant_idx == IDX_W'(i)) begin
                lim_sel = ch_limit[i*WIDTH +: WIDTH];
            end
        end
        lim_m1   = '0;
        mask_sel = '0;
        if (lim_sel >= WIDTH'(2)) begin
            lim_m1   = lim_sel - WIDTH'(1);
            mask_sel = lim_m1;
            for (int b = int'(WIDTH) - 2; b >= 0; b--) begin
                mask_sel[b] = mask_sel[b] | mask_sel[b+1];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        lim_d        = lim_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        tries_d      = tries_q;
        value_d      = value_q;
        candidate    = s_q & mask_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    idx_d   = grant_idx;
                    lim_d   = lim_sel;
                    mask_d  = mask_sel;
                    cnt_d   = CNT_W'(DISCARD - 1);
                    tries_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_TEST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_TEST: begin
                if (lim_q == '0) begin
                    value_d = s_q;
                    state_d = ST_DONE;
                end else if (lim_q == WIDTH'(1)) begin
                    value_d = '0;
                    state_d = ST_DONE;
                end else if (candidate < lim_q) begin
                    value_d = candidate;
                    state_d = ST_DONE;
                end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                    value_d = candidate - lim_q;
                    state_d = ST_DONE;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            ST_DONE: begin
                last_grant_d = idx_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= ST_IDLE;
            s_q          <= SEED;
            idx_q        <= '0;
            last_grant_q <= IDX_W'(NUM_CH - 1);
            lim_q        <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            tries_q      <= '0;
            value_q      <= '0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            lim_q        <= lim_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            tries_q      <= tries_d;
            value_q      <= value_d;
        end
    end

    always_comb begin
        ch_ack = '0;
        if (state_q == ST_DONE) begin
            ch_ack[idx_q] = 1'b1;
        end
    end

    assign random_num_export = s_q;
    assign ch_value          = value_q;
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rng_arbiter_bank.sv
// Directed bench for rng_arbiter_bank: LFSR sequence, bounded draws, rotation, reset and fallback.
module tb_rng_arbiter_bank;

    localparam logic [31:0] SEED = 32'hACE1_2024;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic         clk;
    logic         rst;
    logic         seed_load;
    logic [31:0]  seed_value;
    logic [31:0]  random_num_export;
    logic [3:0]   ch_req;
    logic [127:0] ch_limit;
    logic [3:0]   ch_ack;
    logic [31:0]  ch_value;
    logic         busy;

    int          assert_count = 0;
    int          fail_count   = 0;
    logic [31:0] model_s;
    logic [31:0] last_value;
    logic [31:0] last_test_export;

    rng_arbiter_bank dut (
        .clk_clk           (clk),
        .reset_reset       (rst),
        .seed_load         (seed_load),
        .seed_value        (seed_value),
        .random_num_export (random_num_export),
        .ch_req            (ch_req),
        .ch_limit          (ch_limit),
        .ch_ack            (ch_ack),
        .ch_value          (ch_value),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    // Reference draw starting from the LFSR value seen in the first TEST cycle.
    function automatic void predict(input logic [31:0] s0, input logic [31:0] lim,
                                    output logic [31:0] val, output int r);
        logic [31:0] s;
        logic [31:0] msk;
        logic [31:0] c;
        s   = s0;
        val = 32'h0;
        r   = 0;
        if (lim == 32'h0) begin
            val = s0;
            return;
        end
        if (lim == 32'h1) begin
            return;
        end
        msk = 32'h0;
        while (msk < lim - 32'h1) msk = (msk << 1) | 32'h1;
        for (int t = 0; t < 8; t++) begin
            c = s & msk;
            if (c < lim) begin
                val = c;
                r   = t;
                return;
            end
            if (t == 7) begin
                val = c - lim;
                r   = 7;
                return;
            end
            s = lfsr_step(s);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input int ch, input logic [31:0] lim);
        ch_limit[ch*32 +: 32] = lim;
        ch_req = req;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_s = SEED;
        else if (seed_load) model_s = (seed_value == 32'h0) ? SEED : seed_value;
        else model_s = lfsr_step(model_s);
        #1;
    endtask

    task automatic runDraw(input int ch, input logic [31:0] lim);
        logic [31:0] exp_val;
        int          exp_r;
        int          n;
        logic        got;
        exp_val = 32'h0;
        exp_r   = 0;
        n       = 0;
        got     = 1'b0;
        applyStimulus(4'b0001 << ch, ch, lim);
        tick();
        checkOutput("busy_draw", 32'(busy), 32'h1);
        while (!got && n < 30) begin
            tick();
            n++;
            if (n == 4) begin
                last_test_export = random_num_export;
                checkOutput("lfsr_sync", random_num_export, model_s);
                predict(model_s, lim, exp_val, exp_r);
            end
            if (ch_ack != 4'b0) got = 1'b1;
        end
        checkOutput("ack_seen", 32'(got), 32'h1);
        checkOutput("ack_latency", 32'(n), 32'(5 + exp_r));
        checkOutput("ack_onehot", 32'(ch_ack), 32'(4'b0001 << ch));
        checkOutput("draw_value", ch_value, exp_val);
        last_value = ch_value;
        ch_req = 4'b0;
        tick();
        checkOutput("ack_cleared", 32'(ch_ack), 32'h0);
        checkOutput("busy_idle", 32'(busy), 32'h0);
        checkOutput("value_held", ch_value, exp_val);
    endtask

    initial begin
        logic [9:0]  seen;
        int          over;
        logic [3:0]  order [5];
        int          k;
        int          multi;
        int          n;
        int          ack_count;
        logic        got;

        rst        = 1'b1;
        seed_load  = 1'b0;
        seed_value = 32'h0;
        ch_req     = 4'b0;
        ch_limit   = '0;
        model_s    = SEED;
        last_value = 32'h0;
        last_test_export = 32'h0;

        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_state", random_num_export, 32'hACE1_2024);
        checkOutput("reset_ack", 32'(ch_ack), 32'h0);
        checkOutput("reset_value", ch_value, 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        tick();
        checkOutput("lfsr_step1", random_num_export, 32'h5670_9012);

        seed_load  = 1'b1;
        seed_value = 32'h1;
        tick();
        checkOutput("seed_one", random_num_export, 32'h0000_0001);
        seed_load = 1'b0;
        tick();
        checkOutput("seed_one_step", random_num_export, 32'h8020_0003);
        seed_load  = 1'b1;
        seed_value = 32'h0;
        tick();
        checkOutput("seed_zero", random_num_export, 32'hACE1_2024);
        seed_load = 1'b0;

        seen = '0;
        over = 0;
        for (int i = 0; i < 2000; i++) begin
            runDraw(0, 32'd10);
            if (last_value < 32'd10) seen[last_value[3:0]] = 1'b1;
            else over++;
        end
        checkOutput("lim10_coverage", 32'(seen), 32'h3FF);
        checkOutput("lim10_over", 32'(over), 32'h0);

        runDraw(1, 32'h0);
        checkOutput("lim0_is_state", ch_value, last_test_export);
        runDraw(2, 32'h1);
        checkOutput("lim1_zero", ch_value, 32'h0);

        rst = 1'b1;
        model_s = SEED;
        tick();
        rst = 1'b0;
        ch_limit = '0;
        ch_req = 4'b1111;
        k = 0;
        multi = 0;
        for (int i = 0; i < 100 && k < 5; i++) begin
            tick();
            if (!$onehot0(ch_ack)) multi++;
            if (ch_ack != 4'b0) begin
                order[k] = ch_ack;
                k++;
            end
        end
        ch_req = 4'b0;
        checkOutput("rr_count", 32'(k), 32'd5);
        checkOutput("rr_first", 32'(order[0]), 32'h1);
        checkOutput("rr_second", 32'(order[1]), 32'h2);
        checkOutput("rr_third", 32'(order[2]), 32'h4);
        checkOutput("rr_fourth", 32'(order[3]), 32'h8);
        checkOutput("rr_wrap", 32'(order[4]), 32'h1);
        checkOutput("rr_multi_ack", 32'(multi), 32'h0);
        for (int i = 0; i < 30 && busy; i++) tick();
        checkOutput("rr_drained", 32'(busy), 32'h0);

        applyStimulus(4'b0001, 0, 32'd10);
        tick();
        tick();
        rst = 1'b1;
        model_s = SEED;
        #1;
        checkOutput("rst_wait_ack", 32'(ch_ack), 32'h0);
        checkOutput("rst_wait_busy", 32'(busy), 32'h0);
        checkOutput("rst_wait_state", random_num_export, 32'hACE1_2024);
        checkOutput("rst_wait_value", ch_value, 32'h0);
        ch_req = 4'b0;
        tick();
        rst = 1'b0;
        ack_count = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ch_ack != 4'b0) ack_count++;
        end
        checkOutput("rst_no_ack", 32'(ack_count), 32'h0);

        applyStimulus(4'b1000, 3, 32'h8000_0001);
        tick();
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            tick();
            n++;
            if (n == 3) begin
                seed_load  = 1'b1;
                seed_value = 32'h8000_00FD;
            end
            if (n == 4) begin
                seed_load = 1'b0;
                checkOutput("fb_seed_in_wait", random_num_export, 32'h8000_00FD);
            end
            if (ch_ack != 4'b0) got = 1'b1;
        end
        ch_req = 4'b0;
        checkOutput("fb_latency", 32'(n), 32'd12);
        checkOutput("fb_ack", 32'(ch_ack), 32'h8);
        checkOutput("fb_value", ch_value, 32'h7F3F_8002);
        checkOutput("fb_below_limit", 32'(ch_value < 32'h8000_0001), 32'h1);
        tick();
        checkOutput("fb_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
